// File: rtl/lq_agen_cs_pipe_if.sv
// Handshake and operand/result bundle for the lq_agen_cs_pipe address adder.
// Optional page_xing result bit is present only with LQ_AGEN_PAGE_XING_EN.
interface lq_agen_cs_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_val;
    logic             in_rdy;
    logic [0:WIDTH-1] rs_a;
    logic [0:WIDTH-1] rs_b;
    logic             ci;
    logic             mode32;
    logic             out_val;
    logic             out_rdy;
    logic [0:WIDTH-1] sum;
    logic             co;
`ifdef LQ_AGEN_PAGE_XING_EN
    logic             page_xing;
`endif

    modport master (
        output in_val, rs_a, rs_b, ci, mode32, out_rdy,
`ifdef LQ_AGEN_PAGE_XING_EN
        input  page_xing,
`endif
        input  in_rdy, out_val, sum, co
    );

    modport slave (
        input  in_val, rs_a, rs_b, ci, mode32, out_rdy,
`ifdef LQ_AGEN_PAGE_XING_EN
        output page_xing,
`endif
        output in_rdy, out_val, sum, co
    );
endinterface

// File: rtl/lq_agen_cs_pipe.sv
// Two-stage carry-select effective-address adder with valid/ready flow control.
// Optional 4 KB page-crossing flag enabled by defining LQ_AGEN_PAGE_XING_EN.
module lq_agen_cs_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 8
) (
    input logic              nclk,
    input logic              rst_b,
    lq_agen_cs_pipe_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    // 32-bit mode needs the bit-31/32 boundary to fall between segments.
    localparam bit MODE32_EN = (WIDTH == 64) && ((32 % SEG) == 0);
    localparam int BSEG = MODE32_EN ? (32 / SEG - 1) : 0;

    logic                     w_s1_adv;
    logic                     w_s2_adv;
    logic [NSEG-1:0][SEG-1:0] w_s0;
    logic [NSEG-1:0][SEG-1:0] w_s1;
    logic [NSEG-1:0]          w_c0;
    logic [NSEG-1:0]          w_c1;

    logic                     r_s1_val;
    logic [NSEG-1:0][SEG-1:0] r_s0;
    logic [NSEG-1:0][SEG-1:0] r_s1;
    logic [NSEG-1:0]          r_c0;
    logic [NSEG-1:0]          r_c1;
    logic                     r_ci;
    logic                     r_mode32;

    logic [0:WIDTH-1]         w_sum;
    logic                     w_co;
    logic                     w_carry;
    logic                     w_co32;

    logic                     r_out_val;
    logic [0:WIDTH-1]         r_sum;
    logic                     r_co;

    assign w_s2_adv   = !r_out_val || bus.out_rdy;
    assign w_s1_adv   = !r_s1_val || w_s2_adv;
    assign bus.in_rdy = w_s1_adv;

    always_comb begin
        w_s0 = '0;
        w_s1 = '0;
        w_c0 = '0;
        w_c1 = '0;
        for (int k = 0; k < NSEG; k++) begin
            {w_c0[k], w_s0[k]} = {1'b0, bus.rs_a[k*SEG +: SEG]} + {1'b0, bus.rs_b[k*SEG +: SEG]};
            {w_c1[k], w_s1[k]} = {1'b0, bus.rs_a[k*SEG +: SEG]} + {1'b0, bus.rs_b[k*SEG +: SEG]}
                               + {{SEG{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            r_s1_val <= 1'b0;
            r_s0     <= '0;
            r_s1     <= '0;
            r_c0     <= '0;
            r_c1     <= '0;
            r_ci     <= 1'b0;
            r_mode32 <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_val <= bus.in_val;
            if (bus.in_val) begin
                r_s0     <= w_s0;
                r_s1     <= w_s1;
                r_c0     <= w_c0;
                r_c1     <= w_c1;
                r_ci     <= bus.ci;
                r_mode32 <= bus.mode32;
            end
        end
    end

    // Ripple the segment carries from the LSB segment upward, cutting at bit 31 in 32-bit mode.
    always_comb begin
        w_carry = r_ci;
        w_co32  = 1'b0;
        w_sum   = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (MODE32_EN && r_mode32 && k == BSEG) begin
                w_co32  = w_carry;
                w_carry = 1'b0;
            end
            if (MODE32_EN && r_mode32 && k <= BSEG)
                w_sum[k*SEG +: SEG] = '0;
            else
                w_sum[k*SEG +: SEG] = w_carry ? r_s1[k] : r_s0[k];
            w_carry = w_carry ? r_c1[k] : r_c0[k];
        end
        w_co = (MODE32_EN && r_mode32) ? w_co32 : w_carry;
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            r_out_val <= 1'b0;
            r_sum     <= '0;
            r_co      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_val <= r_s1_val;
            if (r_s1_val) begin
                r_sum <= w_sum;
                r_co  <= w_co;
            end
        end
    end

    assign bus.out_val = r_out_val;
    assign bus.sum     = r_sum;
    assign bus.co      = r_co;

`ifdef LQ_AGEN_PAGE_XING_EN
    // Carry into bit WIDTH-13 recovered as a^b^sum at that bit.
    logic r_pp;
    logic r_page;

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b)
            r_pp <= 1'b0;
        else if (w_s1_adv && bus.in_val)
            r_pp <= bus.rs_a[WIDTH-13] ^ bus.rs_b[WIDTH-13];
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b)
            r_page <= 1'b0;
        else if (w_s2_adv && r_s1_val)
            r_page <= r_pp ^ w_sum[WIDTH-13];
    end

    assign bus.page_xing = r_page;
`endif
endmodule
